// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared AXI4-Lite definitions for the slave and master channel blocks:
//   - BRESP/RRESP encodings (OKAY, EXOKAY, SLVERR, DECERR)
//   - axil_state_t : channel state machine encoding
// -----------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_W  = 3'd1,
        WAIT_AW = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } axil_state_t;

endpackage

// File: rtl/axils_wr_ch.sv
// -----------------------------------------------------------------------------
// axils_wr_ch
// AXI4-Lite slave write channel. It accepts one write at a time. The AW and W
// beats may arrive in either order or together. It issues a one-cycle local
// register write strobe and then returns a write response. Every output comes
// straight from a flop.
//
// Optional build macro:
//   AXILS_WR_ADDR_CHECK_EN - addresses outside [ADDR_LO, ADDR_HI] get no local
//                            strobe and return DECERR. The DECERR takes
//                            priority over REG_WERR.
//
// Ports:
//   ACLK, ARESETn            clock; asynchronous active-low reset
//   AWADDR/AWPROT/AWVALID/AWREADY   write address channel (AWPROT ignored)
//   WDATA/WSTRB/WVALID/WREADY       write data channel
//   BVALID/BREADY/BRESP             write response channel
//   REG_WEN                  one-cycle local write strobe
//   REG_ADDR/REG_WDATA/REG_WSTB     captured write, valid while REG_WEN=1
//   REG_WERR                 local slave error, sampled in the REG_WEN cycle
// -----------------------------------------------------------------------------
module axils_wr_ch
    import axil_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'h0000_0FFF
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    output logic        REG_WEN,
    output logic [31:0] REG_ADDR,
    output logic [31:0] REG_WDATA,
    output logic [3:0]  REG_WSTB,
    input  logic        REG_WERR
);

    axil_state_t state_reg, state_next;
    logic        awready_reg, awready_next;
    logic        wready_reg, wready_next;
    logic        bvalid_reg, bvalid_next;
    logic [1:0]  bresp_reg, bresp_next;
    logic        reg_wen_reg, reg_wen_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstb_reg, wstb_next;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = AWVALID & awready_reg;
    assign w_hs  = WVALID & wready_reg;

`ifdef AXILS_WR_ADDR_CHECK_EN
    // A single wrapped subtraction tests both bounds. It stays correct for
    // ADDR_LO = 0 and avoids a compare that is always true.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a - ADDR_LO) <= (ADDR_HI - ADDR_LO);
    endfunction

    logic unused_ok;
    assign unused_ok = ^{AWPROT, EXOKAY};
`else
    function automatic logic addr_ok(input logic [31:0] a);
        return (a == a);
    endfunction

    logic unused_ok;
    assign unused_ok = ^{AWPROT, EXOKAY, ADDR_LO, ADDR_HI};
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg   <= IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= OKAY;
            reg_wen_reg <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstb_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            bresp_reg   <= bresp_next;
            reg_wen_reg <= reg_wen_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstb_reg    <= wstb_next;
        end
    end

    // Next-state logic. The outputs are registered, so the strobe for WRITE is
    // decided on the edge that enters WRITE. For that reason the address check
    // looks at the address that is being captured on that edge.
    always_comb begin
        state_next   = state_reg;
        awready_next = awready_reg;
        wready_next  = wready_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        reg_wen_next = 1'b0;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstb_next    = wstb_reg;

        case (state_reg)
            IDLE: begin
                // After reset the readies come out of reset low. They rise here
                // on the first edge.
                awready_next = 1'b1;
                wready_next  = 1'b1;
                bvalid_next  = 1'b0;
                if (aw_hs && w_hs) begin
                    addr_next    = AWADDR;
                    wdata_next   = WDATA;
                    wstb_next    = WSTRB;
                    awready_next = 1'b0;
                    wready_next  = 1'b0;
                    reg_wen_next = addr_ok(AWADDR);
                    state_next   = WRITE;
                end else if (aw_hs) begin
                    addr_next    = AWADDR;
                    awready_next = 1'b0;
                    state_next   = WAIT_W;
                end else if (w_hs) begin
                    wdata_next   = WDATA;
                    wstb_next    = WSTRB;
                    wready_next  = 1'b0;
                    state_next   = WAIT_AW;
                end
            end
            WAIT_W: begin
                awready_next = 1'b0;
                wready_next  = 1'b1;
                if (w_hs) begin
                    wdata_next   = WDATA;
                    wstb_next    = WSTRB;
                    wready_next  = 1'b0;
                    reg_wen_next = addr_ok(addr_reg);
                    state_next   = WRITE;
                end
            end
            WAIT_AW: begin
                awready_next = 1'b1;
                wready_next  = 1'b0;
                if (aw_hs) begin
                    addr_next    = AWADDR;
                    awready_next = 1'b0;
                    reg_wen_next = addr_ok(AWADDR);
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                awready_next = 1'b0;
                wready_next  = 1'b0;
                bvalid_next  = 1'b1;
`ifdef AXILS_WR_ADDR_CHECK_EN
                if (!addr_ok(addr_reg)) begin
                    bresp_next = DECERR;
                end else begin
                    bresp_next = REG_WERR ? SLVERR : OKAY;
                end
`else
                bresp_next = REG_WERR ? SLVERR : OKAY;
`endif
                state_next = RESP;
            end
            RESP: begin
                awready_next = 1'b0;
                wready_next  = 1'b0;
                if (bvalid_reg && BREADY) begin
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                awready_next = 1'b0;
                wready_next  = 1'b0;
                bvalid_next  = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    assign AWREADY   = awready_reg;
    assign WREADY    = wready_reg;
    assign BVALID    = bvalid_reg;
    assign BRESP     = bresp_reg;
    assign REG_WEN   = reg_wen_reg;
    assign REG_ADDR  = addr_reg;
    assign REG_WDATA = wdata_reg;
    assign REG_WSTB  = wstb_reg;

endmodule

// File: tb/tb_axils_wr_ch.sv
// -----------------------------------------------------------------------------
// tb_axils_wr_ch
// Directed testbench for axils_wr_ch. Inputs are driven 1 time unit after each
// rising edge. Outputs are checked at the same point, so they reflect the edge
// that was just taken.
// -----------------------------------------------------------------------------
module tb_axils_wr_ch;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        REG_WEN;
    logic [31:0] REG_ADDR;
    logic [31:0] REG_WDATA;
    logic [3:0]  REG_WSTB;
    logic        REG_WERR;

    int checks   = 0;
    int failures = 0;

    axils_wr_ch dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .REG_WEN   (REG_WEN),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_WSTB  (REG_WSTB),
        .REG_WERR  (REG_WERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn  = 1'b1;
        AWADDR   = '0;
        AWPROT   = '0;
        AWVALID  = 1'b0;
        WDATA    = '0;
        WSTRB    = '0;
        WVALID   = 1'b0;
        BREADY   = 1'b0;
        REG_WERR = 1'b0;

        // Asynchronous reset asserted before any clock edge
        #2 ARESETn = 1'b0;
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready",  WREADY,  0);
        check("rst_bvalid",  BVALID,  0);
        check("rst_bresp",   BRESP,   0);
        check("rst_reg_wen", REG_WEN, 0);
        check("rst_reg_addr", REG_ADDR, 0);
        check("rst_reg_wdata", REG_WDATA, 0);
        check("rst_reg_wstb", REG_WSTB, 0);
        step();
        step();
        ARESETn = 1'b1;
        check("rel_awready_low", AWREADY, 0);
        step();
        check("rel_awready_up", AWREADY, 1);
        check("rel_wready_up",  WREADY,  1);
        $display("txn reset: ready after release");

        // AW and W in the same cycle
        AWADDR = 32'h10; AWVALID = 1'b1;
        WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b1;
        step();
        check("t1_wen",   REG_WEN, 1);
        check("t1_addr",  REG_ADDR, 32'h10);
        check("t1_wdata", REG_WDATA, 32'hA5A5_A5A5);
        check("t1_wstb",  REG_WSTB, 4'hF);
        check("t1_awready", AWREADY, 0);
        check("t1_wready",  WREADY, 0);
        check("t1_bvalid0", BVALID, 0);
        AWVALID = 1'b0; WVALID = 1'b0;
        AWADDR = 32'hFFFF_FFFF; WDATA = 32'hDEAD_BEEF;
        step();
        check("t1_wen_off", REG_WEN, 0);
        check("t1_bvalid", BVALID, 1);
        check("t1_bresp",  BRESP, 2'b00);
        check("t1_addr_hold", REG_ADDR, 32'h10);
        step();
        check("t1_bvalid_off", BVALID, 0);
        check("t1_idle_awready", AWREADY, 1);
        check("t1_idle_wready",  WREADY, 1);
        $display("txn 1: addr=0x10 data=0xa5a5a5a5 same-cycle");

        // AW first, then W three cycles later
        AWADDR = 32'h20; AWVALID = 1'b1;
        step();
        check("t2_awready_c1", AWREADY, 0);
        check("t2_wready_c1",  WREADY, 1);
        AWVALID = 1'b0; AWADDR = 32'h0000_DEAD;
        step();
        check("t2_awready_c2", AWREADY, 0);
        check("t2_wen_c2", REG_WEN, 0);
        step();
        check("t2_awready_c3", AWREADY, 0);
        WDATA = 32'h1234; WSTRB = 4'h3; WVALID = 1'b1;
        step();
        check("t2_wen",   REG_WEN, 1);
        check("t2_addr",  REG_ADDR, 32'h20);
        check("t2_wdata", REG_WDATA, 32'h1234);
        check("t2_wstb",  REG_WSTB, 4'h3);
        WVALID = 1'b0;
        step();
        check("t2_bvalid", BVALID, 1);
        check("t2_bresp",  BRESP, 2'b00);
        step();
        check("t2_idle", AWREADY, 1);
        $display("txn 2: addr=0x20 data=0x1234 aw-first");

        // W first, then AW; local slave error; BREADY held low for 5 cycles
        WDATA = 32'hCAFE_F00D; WSTRB = 4'h5; WVALID = 1'b1;
        step();
        check("t3_wready", WREADY, 0);
        check("t3_awready", AWREADY, 1);
        WVALID = 1'b0;
        AWADDR = 32'h44; AWVALID = 1'b1;
        step();
        check("t3_wen",   REG_WEN, 1);
        check("t3_addr",  REG_ADDR, 32'h44);
        check("t3_wdata", REG_WDATA, 32'hCAFE_F00D);
        check("t3_wstb",  REG_WSTB, 4'h5);
        AWVALID = 1'b0;
        REG_WERR = 1'b1;
        BREADY = 1'b0;
        step();
        REG_WERR = 1'b0;
        check("t3_bvalid", BVALID, 1);
        check("t3_bresp",  BRESP, 2'b10);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_stall_bvalid", BVALID, 1);
            check("t3_stall_bresp",  BRESP, 2'b10);
            check("t3_stall_awready", AWREADY, 0);
            check("t3_stall_wready",  WREADY, 0);
        end
        BREADY = 1'b1;
        step();
        check("t3_release_bvalid", BVALID, 0);
        check("t3_release_awready", AWREADY, 1);
        check("t3_release_wready",  WREADY, 1);
        $display("txn 3: addr=0x44 data=0xcafef00d w-first slverr");

        // WSTRB all zero still writes
        AWADDR = 32'h8; AWVALID = 1'b1;
        WDATA = 32'h55; WSTRB = 4'h0; WVALID = 1'b1;
        step();
        check("t4_wen",  REG_WEN, 1);
        check("t4_wstb", REG_WSTB, 4'h0);
        AWVALID = 1'b0; WVALID = 1'b0;
        step();
        check("t4_bvalid", BVALID, 1);
        check("t4_bresp",  BRESP, 2'b00);
        step();
        $display("txn 4: addr=0x8 wstrb=0");

        // Address outside the default range
        AWADDR = 32'h2000; AWVALID = 1'b1;
        WDATA = 32'h99; WSTRB = 4'hF; WVALID = 1'b1;
        step();
`ifdef AXILS_WR_ADDR_CHECK_EN
        check("t5_wen", REG_WEN, 0);
        REG_WERR = 1'b1;
`else
        check("t5_wen", REG_WEN, 1);
        check("t5_addr", REG_ADDR, 32'h2000);
`endif
        AWVALID = 1'b0; WVALID = 1'b0;
        step();
        REG_WERR = 1'b0;
        check("t5_bvalid", BVALID, 1);
`ifdef AXILS_WR_ADDR_CHECK_EN
        check("t5_bresp", BRESP, 2'b11);
`else
        check("t5_bresp", BRESP, 2'b00);
`endif
        step();
        $display("txn 5: addr=0x2000 out-of-range");

        // Reset while waiting for W
        AWADDR = 32'h30; AWVALID = 1'b1;
        step();
        check("t6_wait_w_awready", AWREADY, 0);
        check("t6_wait_w_wready",  WREADY, 1);
        AWVALID = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        check("t6_rst_wready",  WREADY, 0);
        check("t6_rst_awready", AWREADY, 0);
        check("t6_rst_addr",    REG_ADDR, 0);
        check("t6_rst_bvalid",  BVALID, 0);
        check("t6_rst_wen",     REG_WEN, 0);
        WDATA = 32'h6666; WSTRB = 4'hF; WVALID = 1'b1;
        step();
        check("t6_in_rst_wready", WREADY, 0);
        ARESETn = 1'b1;
        WVALID = 1'b0;
        step();
        check("t6_rel_awready", AWREADY, 1);
        check("t6_rel_wready",  WREADY, 1);
        for (int i = 0; i < 3; i++) begin
            check("t6_no_wen",    REG_WEN, 0);
            check("t6_no_bvalid", BVALID, 0);
            step();
        end
        $display("txn 6: reset during WAIT_W discarded");

        // Normal write after the mid-transaction reset
        AWADDR = 32'h3C; AWVALID = 1'b1;
        WDATA = 32'h77; WSTRB = 4'h1; WVALID = 1'b1;
        step();
        check("t7_wen",   REG_WEN, 1);
        check("t7_addr",  REG_ADDR, 32'h3C);
        check("t7_wdata", REG_WDATA, 32'h77);
        AWVALID = 1'b0; WVALID = 1'b0;
        step();
        check("t7_bvalid", BVALID, 1);
        check("t7_bresp",  BRESP, 2'b00);
        step();
        $display("txn 7: addr=0x3c data=0x77 after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
